// File: rtl/stage_sequencer.sv
// -----------------------------------------------------------------------------
// stage_sequencer
//
// Multi-cycle processor control sequencer. It walks each instruction through
// IF -> ID -> EX -> (MEM) -> WB, generates the per-stage enables, counts
// retired instructions, and parks in HALT when the decoder flags a halt.
//
// Ports
//   clk         : single clock, all state changes on its rising edge
//   rstd        : asynchronous active-low reset
//   start       : begin execution from IDLE
//   imem_ready  : instruction memory read complete (used only in IF)
//   dmem_ready  : data memory access complete (used only in MEM)
//   opclass     : decoder class 00 ALU, 01 LOAD, 10 STORE, 11 BRANCH/JUMP
//   halt_instr  : decoder flags a halt instruction (sampled in ID)
//   imem_req    : instruction fetch request
//   ir_we       : instruction register load enable
//   dmem_req    : data memory request
//   dmem_we     : data memory write, qualified by dmem_req
//   rf_we       : register file write enable
//   pc_we       : latch nextpc into pc
//   state       : current FSM state encoding
//   halted      : high while in HALT
//   retired     : count of completed instructions, wraps silently
// -----------------------------------------------------------------------------
module stage_sequencer #(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rstd,
    input  logic               start,
    input  logic               imem_ready,
    input  logic               dmem_ready,
    input  logic [1:0]         opclass,
    input  logic               halt_instr,
    output logic               imem_req,
    output logic               ir_we,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic               rf_we,
    output logic               pc_we,
    output logic [2:0]         state,
    output logic               halted,
    output logic [COUNT_W-1:0] retired
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_IF   = 3'd1;
    localparam logic [2:0] S_ID   = 3'd2;
    localparam logic [2:0] S_EX   = 3'd3;
    localparam logic [2:0] S_MEM  = 3'd4;
    localparam logic [2:0] S_WB   = 3'd5;
    localparam logic [2:0] S_HALT = 3'd6;

    localparam logic [1:0] C_ALU    = 2'b00;
    localparam logic [1:0] C_LOAD   = 2'b01;
    localparam logic [1:0] C_STORE  = 2'b10;

    localparam logic [COUNT_W-1:0] ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    logic [2:0]         r_state;
    logic [2:0]         w_state_next;
    logic [1:0]         r_class;
    logic [COUNT_W-1:0] r_retired;

    // Class is only needed after ID; holding it here keeps later stages
    // immune to the decoder output changing once the instruction moves on.
    logic w_is_mem;
    assign w_is_mem = (r_class == C_LOAD) || (r_class == C_STORE);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (start)      w_state_next = S_IF;
            S_IF:   if (imem_ready) w_state_next = S_ID;
            S_ID:   w_state_next = halt_instr ? S_HALT : S_EX;
            S_EX:   w_state_next = w_is_mem ? S_MEM : S_WB;
            S_MEM:  if (dmem_ready) w_state_next = S_WB;
            S_WB:   w_state_next = S_IF;
            S_HALT: w_state_next = S_HALT;
            default: w_state_next = S_IDLE;   // illegal code recovers in one cycle
        endcase
    end

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            r_state   <= S_IDLE;
            r_class   <= C_ALU;
            r_retired <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_ID) begin
                r_class <= opclass;
            end
            if (r_state == S_WB) begin
                r_retired <= r_retired + ONE;
            end
        end
    end

    // All enables decode directly from the state register (plus the ready
    // strobes where the handshake completes in the same cycle), so reset
    // clears them without waiting for a clock edge.
    assign imem_req = (r_state == S_IF);
    assign ir_we    = (r_state == S_IF) && imem_ready;
    assign dmem_req = (r_state == S_MEM);
    assign dmem_we  = (r_state == S_MEM) && (r_class == C_STORE);
    assign pc_we    = (r_state == S_WB);
    assign rf_we    = (r_state == S_WB) && !r_class[1];  // ALU or LOAD
    assign halted   = (r_state == S_HALT);
    assign state    = r_state;
    assign retired  = r_retired;

endmodule

// File: tb/tb_stage_sequencer.sv
// -----------------------------------------------------------------------------
// tb_stage_sequencer
//
// Directed bench for stage_sequencer (COUNT_W=4 so the retired counter wrap
// is reachable). Outputs are checked 2 ns after each rising edge.
// Packed output vector bit order:
//   {imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, halted}
// -----------------------------------------------------------------------------
module tb_stage_sequencer;

    localparam int CW = 4;

    localparam logic [6:0] O_IMEM = 7'b1000000;
    localparam logic [6:0] O_IRWE = 7'b0100000;
    localparam logic [6:0] O_DREQ = 7'b0010000;
    localparam logic [6:0] O_DWE  = 7'b0001000;
    localparam logic [6:0] O_RFWE = 7'b0000100;
    localparam logic [6:0] O_PCWE = 7'b0000010;
    localparam logic [6:0] O_HALT = 7'b0000001;

    logic          clk = 1'b0;
    logic          rstd;
    logic          start;
    logic          imem_ready;
    logic          dmem_ready;
    logic [1:0]    opclass;
    logic          halt_instr;
    logic          imem_req;
    logic          ir_we;
    logic          dmem_req;
    logic          dmem_we;
    logic          rf_we;
    logic          pc_we;
    logic [2:0]    state;
    logic          halted;
    logic [CW-1:0] retired;

    int checks = 0;
    int errors = 0;
    logic [CW-1:0] exp_ret = '0;

    always #5 clk = ~clk;

    stage_sequencer #(.COUNT_W(CW)) dut (
        .clk        (clk),
        .rstd       (rstd),
        .start      (start),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .opclass    (opclass),
        .halt_instr (halt_instr),
        .imem_req   (imem_req),
        .ir_we      (ir_we),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .rf_we      (rf_we),
        .pc_we      (pc_we),
        .state      (state),
        .halted     (halted),
        .retired    (retired)
    );

    logic [6:0] outs;
    assign outs = {imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, halted};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction starting with the FSM in IF (called 1 ns after an
    // edge). cls is presented in ID; cls_after replaces it from EX onwards.
    task automatic do_instr(input string tag, input logic [1:0] cls,
                            input logic [1:0] cls_after,
                            input int imem_wait, input int dmem_wait);
        logic       is_mem;
        logic [6:0] mem_outs;
        logic [6:0] wb_outs;
        is_mem   = (cls == 2'b01) || (cls == 2'b10);
        mem_outs = O_DREQ | ((cls == 2'b10) ? O_DWE : 7'b0);
        wb_outs  = O_PCWE | ((cls == 2'b00 || cls == 2'b01) ? O_RFWE : 7'b0);
        // IF wait cycles; dmem_ready high here must be ignored
        imem_ready = 1'b0;
        dmem_ready = 1'b1;
        for (int i = 0; i < imem_wait; i++) begin
            #1;
            chk({tag, "_if_wait_state"}, state, 3'd1);
            chk({tag, "_if_wait_outs"}, outs, O_IMEM);
            tick();
        end
        imem_ready = 1'b1;
        dmem_ready = 1'b0;
        opclass    = 2'b11;
        #1;
        chk({tag, "_if_state"}, state, 3'd1);
        chk({tag, "_if_outs"}, outs, O_IMEM | O_IRWE);
        tick();
        // ID: class captured here; strobes must be ignored
        opclass    = cls;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        #1;
        chk({tag, "_id_state"}, state, 3'd2);
        chk({tag, "_id_outs"}, outs, 7'b0);
        tick();
        opclass    = cls_after;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        #1;
        chk({tag, "_ex_state"}, state, 3'd3);
        chk({tag, "_ex_outs"}, outs, 7'b0);
        tick();
        if (is_mem) begin
            for (int i = 0; i < dmem_wait; i++) begin
                #1;
                chk({tag, "_mem_wait_state"}, state, 3'd4);
                chk({tag, "_mem_wait_outs"}, outs, mem_outs);
                tick();
            end
            dmem_ready = 1'b1;
            #1;
            chk({tag, "_mem_state"}, state, 3'd4);
            chk({tag, "_mem_outs"}, outs, mem_outs);
            tick();
            dmem_ready = 1'b0;
        end
        #1;
        chk({tag, "_wb_state"}, state, 3'd5);
        chk({tag, "_wb_outs"}, outs, wb_outs);
        chk({tag, "_wb_retired"}, retired, exp_ret);
        tick();
        exp_ret = exp_ret + 1'b1;
        #1;
        chk({tag, "_next_if_state"}, state, 3'd1);
        chk({tag, "_retired"}, retired, exp_ret);
        $display("instr %s class=%0d retired=%0d", tag, cls, retired);
    endtask

    initial begin
        rstd       = 1'b0;
        start      = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        opclass    = 2'b00;
        halt_instr = 1'b0;
        #2;
        chk("reset_state", state, 3'd0);
        chk("reset_outs", outs, 7'b0);
        chk("reset_retired", retired, 0);
        rstd  = 1'b1;
        start = 1'b1;
        tick();                                    // t=6, edge at 5
        start = 1'b0;
        chk("start_to_if", state, 3'd1);
        chk("if_imem_req_wait", outs, O_IMEM);
        #4;                                        // t=10, mid-IF, imem_ready=0
        rstd = 1'b0;
        #1;
        chk("async_rst_state", state, 3'd0);
        chk("async_rst_outs", outs, 7'b0);
        chk("async_rst_retired", retired, 0);
        $display("reset during IF at 10ns state=%0d", state);
        #1;
        rstd = 1'b1;
        tick();                                    // no start: stay IDLE
        chk("idle_hold", state, 3'd0);
        chk("idle_outs", outs, 7'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_if", state, 3'd1);

        do_instr("alu",    2'b00, 2'b00, 0, 0);
        do_instr("load",   2'b01, 2'b01, 0, 3);
        do_instr("store",  2'b10, 2'b00, 0, 0);
        do_instr("branch", 2'b11, 2'b01, 2, 0);
        for (int n = 0; n < 12; n++) begin
            do_instr("alu_wrap", 2'b00, 2'b00, 0, 0);
        end
        chk("retired_wrapped", retired, 0);

        // Halt path
        imem_ready = 1'b1;
        tick();
        halt_instr = 1'b1;
        imem_ready = 1'b0;
        #1;
        chk("halt_id_state", state, 3'd2);
        tick();
        halt_instr = 1'b0;
        chk("halt_state", state, 3'd6);
        chk("halt_outs", outs, O_HALT);
        for (int i = 0; i < 3; i++) begin
            start      = 1'b1;
            imem_ready = 1'b1;
            dmem_ready = 1'b1;
            tick();
            start      = 1'b0;
            chk("halt_stays", state, 3'd6);
            chk("halt_stays_outs", outs, O_HALT);
        end
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        chk("halt_retired", retired, exp_ret);
        #2;
        rstd = 1'b0;
        #1;
        chk("halt_rst_state", state, 3'd0);
        chk("halt_rst_outs", outs, 7'b0);
        chk("halt_rst_retired", retired, 0);
        $display("halt exited by reset state=%0d", state);
        #2;
        rstd = 1'b1;
        tick();
        chk("post_halt_idle", state, 3'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
